final_layer_chunked_argmax: RTL and testbench

//  Parametrised, chunk-serial successor of the BNN output layer.
//  - Computes popcount(XNOR(data, weights[c])) for NUM_CLASSES class neurons.
//  - Processes CHUNK_W bits per cycle, fetching weights by address from an external ROM.
//  - Reports the argmax class, its score and a done pulse.
//  - Sits after the flatten stage; trades latency for much less popcount logic.

---
 rtl/final_layer_chunked_argmax.sv | 151 +++++++++++++++
 tb/tb_final_layer_chunked_argmax.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/final_layer_chunked_argmax.sv
`timescale 1ns/1ps
// Chunk-serial BNN output layer: popcount(XNOR(data, weights[c])) per class, argmax out.
// Latency: layer_3_done rises NUM_CLASSES*NUM_CHUNKS en-edges after the accepted start edge.
// Backpressure: en=0 freezes every register; start is ignored unless IDLE, never queued.
module final_layer_chunked_argmax #(
    parameter int NUM_INPUTS  = 196,
    parameter int NUM_CLASSES = 10,
    parameter int CHUNK_W     = 28,
    localparam int NUM_CHUNKS = (NUM_INPUTS + CHUNK_W - 1) / CHUNK_W,
    localparam int CLS_W      = $clog2(NUM_CLASSES),
    localparam int CHK_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int SCORE_W    = $clog2(NUM_INPUTS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  start,
    input  logic [NUM_INPUTS-1:0] data_in,
    output logic [CLS_W-1:0]      wt_class,
    output logic [CHK_W-1:0]      wt_chunk,
    input  logic [CHUNK_W-1:0]    wt_data,
    output logic                  busy,
    output logic [CLS_W-1:0]      answer,
    output logic [SCORE_W-1:0]    best_score,
    output logic                  layer_3_done
);

    // Activations are zero-extended to a whole number of chunks so the last
    // (possibly partial) chunk can be sliced like any other.
    localparam int PAD_W = NUM_CHUNKS * CHUNK_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CHK_W-1:0] LAST_CHUNK = CHK_W'(NUM_CHUNKS - 1);
    localparam logic [CLS_W-1:0] LAST_CLASS = CLS_W'(NUM_CLASSES - 1);

    logic [1:0]            state;
    logic [NUM_INPUTS-1:0] data_reg;
    logic [SCORE_W-1:0]    acc;

    logic [PAD_W-1:0]      data_pad;
    logic [PAD_W-1:0]      valid_pad;
    logic [CHUNK_W-1:0]    data_chunk;
    logic [CHUNK_W-1:0]    mask_chunk;
    logic [CHUNK_W-1:0]    match;
    logic [SCORE_W-1:0]    pop;
    logic [SCORE_W-1:0]    score;
    logic                  last_chunk;
    logic                  last_class;
    logic                  better;

    // Padded copies of the latched activations and of the "real bit" mask;
    // pad positions are zero in the mask so they never add to a score.
    always_comb begin
        data_pad                   = '0;
        data_pad[NUM_INPUTS-1:0]   = data_reg;
        valid_pad                  = '0;
        valid_pad[NUM_INPUTS-1:0]  = '1;
    end

    // Select the chunk currently addressed by the weight ROM counters.
    always_comb begin
        data_chunk = data_pad[int'(wt_chunk) * CHUNK_W +: CHUNK_W];
        mask_chunk = valid_pad[int'(wt_chunk) * CHUNK_W +: CHUNK_W];
        match      = ~(data_chunk ^ wt_data) & mask_chunk;
    end

    // Popcount of the matching bits in this chunk; fits SCORE_W because
    // CHUNK_W never exceeds NUM_INPUTS.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            pop = pop + SCORE_W'(match[i]);
        end
    end

    // Running class score and the argmax decision for the final chunk.
    // Strict greater-than keeps the lowest class index on ties.
    always_comb begin
        score      = acc + pop;
        last_chunk = (wt_chunk == LAST_CHUNK);
        last_class = (wt_class == LAST_CLASS);
        better     = (wt_class == '0) || (score > best_score);
    end

    // Control FSM, accumulator, address counters and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            data_reg     <= '0;
            acc          <= '0;
            wt_class     <= '0;
            wt_chunk     <= '0;
            busy         <= 1'b0;
            answer       <= '0;
            best_score   <= '0;
            layer_3_done <= 1'b0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    layer_3_done <= 1'b0;
                    if (start) begin
                        data_reg   <= data_in;
                        acc        <= '0;
                        wt_class   <= '0;
                        wt_chunk   <= '0;
                        best_score <= '0;
                        answer     <= '0;
                        busy       <= 1'b1;
                        state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!last_chunk) begin
                        acc      <= score;
                        wt_chunk <= wt_chunk + CHK_W'(1);
                    end else begin
                        acc      <= '0;
                        wt_chunk <= '0;
                        if (better) begin
                            best_score <= score;
                            answer     <= wt_class;
                        end
                        if (last_class) begin
                            // Counters return to zero so the ROM address idles at class 0.
                            wt_class     <= '0;
                            busy         <= 1'b0;
                            layer_3_done <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            wt_class <= wt_class + CLS_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // The done pulse lasts exactly one en-edge; start here is dropped.
                    layer_3_done <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    busy         <= 1'b0;
                    layer_3_done <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_final_layer_chunked_argmax.sv
`timescale 1ns/1ps
// Directed bench for the chunk-serial argmax layer (CHUNK_W=28 and CHUNK_W=30 instances).
// Latency: each inference is expected to complete in 70 en-edges.
// Backpressure: en stall and ignored-start cases are driven explicitly.
module tb_final_layer_chunked_argmax;

    logic         clock;
    logic         reset;
    logic         en;
    logic         start;
    logic [195:0] data_in;

    logic [3:0]   wt_class;
    logic [2:0]   wt_chunk;
    logic [27:0]  wt_data;
    logic         busy;
    logic [3:0]   answer;
    logic [7:0]   best_score;
    logic         layer_3_done;

    logic [3:0]   wt_class30;
    logic [2:0]   wt_chunk30;
    logic [29:0]  wt_data30;
    logic         busy30;
    logic [3:0]   answer30;
    logic [7:0]   best_score30;
    logic         layer_3_done30;

    logic [209:0] wmem [16];

    int n_checks = 0;
    int n_fail   = 0;

    final_layer_chunked_argmax #(.NUM_INPUTS(196), .NUM_CLASSES(10), .CHUNK_W(28)) dut (
        .clock(clock), .reset(reset), .en(en), .start(start), .data_in(data_in),
        .wt_class(wt_class), .wt_chunk(wt_chunk), .wt_data(wt_data),
        .busy(busy), .answer(answer), .best_score(best_score), .layer_3_done(layer_3_done)
    );

    final_layer_chunked_argmax #(.NUM_INPUTS(196), .NUM_CLASSES(10), .CHUNK_W(30)) dut30 (
        .clock(clock), .reset(reset), .en(en), .start(start), .data_in(data_in),
        .wt_class(wt_class30), .wt_chunk(wt_chunk30), .wt_data(wt_data30),
        .busy(busy30), .answer(answer30), .best_score(best_score30), .layer_3_done(layer_3_done30)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Weight ROM models: combinational, pad bits above 195 are always zero.
    always_comb begin
        wt_data   = wmem[wt_class][int'(wt_chunk) * 28 +: 28];
        wt_data30 = wmem[wt_class30][int'(wt_chunk30) * 30 +: 30];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_weights();
        for (int c = 0; c < 16; c++) wmem[c] = '0;
    endtask

    task automatic load_single_winner();
        clear_weights();
        wmem[4][195:0] = '1;
    endtask

    task automatic load_staircase();
        clear_weights();
        for (int c = 0; c < 10; c++)
            for (int j = 0; j <= c; j++) wmem[c][j] = 1'b1;
    endtask

    // Issue a start and count edges until done (capped at 200).
    task automatic run(output int edges);
        start = 1'b1;
        en    = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
        while (edges < 200) begin
            step();
            edges++;
            if (layer_3_done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; start = 1'b0; data_in = '0;
        step(); step();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d want 0", busy); end
        n_checks++; if (layer_3_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d want 0", layer_3_done); end
        n_checks++; if (answer !== 4'd0) begin n_fail++; $display("FAIL reset_answer: got %0d want 0", answer); end
        n_checks++; if (best_score !== 8'd0) begin n_fail++; $display("FAIL reset_best: got %0d want 0", best_score); end
        n_checks++; if (wt_class !== 4'd0) begin n_fail++; $display("FAIL reset_wt_class: got %0d want 0", wt_class); end
        n_checks++; if (wt_chunk !== 3'd0) begin n_fail++; $display("FAIL reset_wt_chunk: got %0d want 0", wt_chunk); end
    endtask

    task automatic test_single_winner();
        int edges;
        data_in = '1;
        load_single_winner();
        run(edges);
        n_checks++; if (edges !== 70) begin n_fail++; $display("FAIL single_latency: got %0d want 70", edges); end
        n_checks++; if (answer !== 4'd4) begin n_fail++; $display("FAIL single_answer: got %0d want 4", answer); end
        n_checks++; if (best_score !== 8'd196) begin n_fail++; $display("FAIL single_best: got %0d want 196", best_score); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done: got %0d want 0", busy); end
        step();
        n_checks++; if (layer_3_done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %0d want 0", layer_3_done); end
        n_checks++; if (answer !== 4'd4) begin n_fail++; $display("FAIL single_answer_hold: got %0d want 4", answer); end
    endtask

    task automatic test_staircase();
        int edges;
        data_in = '1;
        load_staircase();
        run(edges);
        n_checks++; if (answer !== 4'd9) begin n_fail++; $display("FAIL stair_answer: got %0d want 9", answer); end
        n_checks++; if (best_score !== 8'd10) begin n_fail++; $display("FAIL stair_best: got %0d want 10", best_score); end
        n_checks++; if (best_score30 !== 8'd10) begin n_fail++; $display("FAIL stair_best_c30: got %0d want 10", best_score30); end
        step();
    endtask

    task automatic test_tie();
        int edges;
        data_in = '1;
        clear_weights();
        for (int c = 0; c < 10; c++) wmem[c][99:0] = '1;
        run(edges);
        n_checks++; if (answer !== 4'd0) begin n_fail++; $display("FAIL tie_answer: got %0d want 0", answer); end
        n_checks++; if (best_score !== 8'd100) begin n_fail++; $display("FAIL tie_best: got %0d want 100", best_score); end
        n_checks++; if (answer30 !== 4'd0) begin n_fail++; $display("FAIL tie_answer_c30: got %0d want 0", answer30); end
        step();
    endtask

    task automatic test_partial_chunk();
        int edges;
        data_in = '0;
        clear_weights();
        run(edges);
        n_checks++; if (layer_3_done30 !== 1'b1) begin n_fail++; $display("FAIL partial_done_c30: got %0d want 1", layer_3_done30); end
        n_checks++; if (best_score30 !== 8'd196) begin n_fail++; $display("FAIL partial_best_c30: got %0d want 196", best_score30); end
        n_checks++; if (answer30 !== 4'd0) begin n_fail++; $display("FAIL partial_answer_c30: got %0d want 0", answer30); end
        n_checks++; if (best_score !== 8'd196) begin n_fail++; $display("FAIL partial_best_c28: got %0d want 196", best_score); end
        step();
    endtask

    task automatic test_stall();
        int k;
        data_in = '1;
        load_single_winner();
        start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (k < 200) begin
            en    = !(k + 1 >= 21 && k + 1 <= 25);
            start = (k + 1 == 40);
            step();
            k++;
            if (k == 25) begin
                n_checks++; if (wt_class !== 4'd2 || wt_chunk !== 3'd6) begin n_fail++; $display("FAIL stall_hold_addr: got class %0d chunk %0d want 2 6", wt_class, wt_chunk); end
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %0d want 1", busy); end
            end
            if (layer_3_done) break;
        end
        start = 1'b0;
        n_checks++; if (k !== 75) begin n_fail++; $display("FAIL stall_latency: got %0d want 75", k); end
        n_checks++; if (answer !== 4'd4 || best_score !== 8'd196) begin n_fail++; $display("FAIL stall_result: got %0d/%0d want 4/196", answer, best_score); end
        en = 1'b0;
        step(); step();
        n_checks++; if (layer_3_done !== 1'b1) begin n_fail++; $display("FAIL stall_done_held: got %0d want 1", layer_3_done); end
        en = 1'b1;
        step();
        n_checks++; if (layer_3_done !== 1'b0) begin n_fail++; $display("FAIL stall_done_release: got %0d want 0", layer_3_done); end
        repeat (5) step();
        n_checks++; if (busy !== 1'b0 || layer_3_done !== 1'b0) begin n_fail++; $display("FAIL stall_no_rerun: got busy %0d done %0d want 0 0", busy, layer_3_done); end
    endtask

    task automatic test_reset_abort();
        int edges;
        bit seen_done;
        data_in = '1;
        load_staircase();
        start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        seen_done = 1'b0;
        repeat (30) begin step(); if (layer_3_done) seen_done = 1'b1; end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || wt_class !== 4'd0 || wt_chunk !== 3'd0) begin n_fail++; $display("FAIL abort_state: got busy %0d class %0d chunk %0d want 0 0 0", busy, wt_class, wt_chunk); end
        n_checks++; if (answer !== 4'd0 || best_score !== 8'd0) begin n_fail++; $display("FAIL abort_result: got %0d/%0d want 0/0", answer, best_score); end
        repeat (80) begin step(); if (layer_3_done) seen_done = 1'b1; end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", seen_done); end
        load_single_winner();
        run(edges);
        n_checks++; if (edges !== 70) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d want 70", edges); end
        n_checks++; if (answer !== 4'd4 || best_score !== 8'd196) begin n_fail++; $display("FAIL abort_rerun_result: got %0d/%0d want 4/196", answer, best_score); end
    endtask

    task automatic test_back_to_back();
        int edges;
        // Entered in DONE from the previous run: start here must be dropped.
        data_in = '1;
        load_staircase();
        start = 1'b1; en = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: got busy %0d want 0", busy); end
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_in_idle: got busy %0d want 1", busy); end
        edges = 0;
        while (edges < 200) begin
            step();
            edges++;
            if (layer_3_done) break;
        end
        n_checks++; if (edges !== 70) begin n_fail++; $display("FAIL b2b_latency: got %0d want 70", edges); end
        n_checks++; if (answer !== 4'd9 || best_score !== 8'd10) begin n_fail++; $display("FAIL b2b_result: got %0d/%0d want 9/10", answer, best_score); end
    endtask

    initial begin
        clear_weights();
        test_reset();
        test_single_winner();
        test_staircase();
        test_tie();
        test_partial_chunk();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
